// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg -- shared definitions for the RV32I memory-access stage.
//
// Holds the instruction-code constants seen on the EX/MEM register, the
// bus widths, the stage FSM encoding and small decode helpers used by
// mem_stage and its load-extension sub-module.
package mem_stage_pkg;

    // Bus widths
    localparam int INST_W = 6;
    localparam int REG_W  = 5;
    localparam int XLEN   = 32;
    localparam int BYTE_W = 8;

    typedef logic [INST_W-1:0] inst_t;

    // Instruction codes carried through the pipeline
    localparam inst_t INST_NOP = 6'd0;
    localparam inst_t INST_ADD = 6'd1;
    localparam inst_t INST_LB  = 6'd16;
    localparam inst_t INST_LH  = 6'd17;
    localparam inst_t INST_LW  = 6'd18;
    localparam inst_t INST_LBU = 6'd19;
    localparam inst_t INST_LHU = 6'd20;
    localparam inst_t INST_SB  = 6'd21;
    localparam inst_t INST_SH  = 6'd22;
    localparam inst_t INST_SW  = 6'd23;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    function automatic logic is_load(input inst_t inst);
        return (inst == INST_LB) || (inst == INST_LH) || (inst == INST_LW) ||
               (inst == INST_LBU) || (inst == INST_LHU);
    endfunction

    function automatic logic is_store(input inst_t inst);
        return (inst == INST_SB) || (inst == INST_SH) || (inst == INST_SW);
    endfunction

    function automatic logic is_signed_load(input inst_t inst);
        return (inst == INST_LB) || (inst == INST_LH);
    endfunction

    // Number of bytes moved by a memory op: 1, 2 or 4.
    function automatic logic [2:0] byte_count(input inst_t inst);
        case (inst)
            INST_LB, INST_LBU, INST_SB: return 3'd1;
            INST_LH, INST_LHU, INST_SH: return 3'd2;
            default:                    return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ld_ext.sv
// mem_ld_ext -- combinational sign/zero extension of an assembled load.
//
// Ports:
//   data_i    assembled little-endian load bytes (upper bytes ignored for n<4)
//   nbytes_i  byte count of the load: 1, 2 or 4
//   signed_i  1 = sign-extend from bit 8n-1, 0 = zero-extend
//   ext_o     32-bit extended result
module mem_ld_ext
    import mem_stage_pkg::*;
(
    input  logic [XLEN-1:0] data_i,
    input  logic [2:0]      nbytes_i,
    input  logic            signed_i,
    output logic [XLEN-1:0] ext_o
);

    always_comb begin
        case (nbytes_i)
            3'd1:    ext_o = {{24{signed_i & data_i[7]}},  data_i[7:0]};
            3'd2:    ext_o = {{16{signed_i & data_i[15]}}, data_i[15:0]};
            default: ext_o = data_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage -- memory-access stage of the 5-stage RV32I pipeline.
//
// Non-memory instructions pass combinationally to MEM/WB. Loads and stores
// are run one byte at a time over the 8-bit memory-controller port while
// the upstream pipeline is stalled; load bytes are assembled little-endian
// and extended by mem_ld_ext.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   rdy             global ready; low freezes all state
//   ex_*            EX/MEM register contents (inst, rd, vd, w_enable,
//                   mem_addr, store_data)
//   mem_*           MEM/WB outputs (inst, rd, vd, w_enable) and stall request
//   mc_*            byte-serial memory-controller port
//   fwd_*           ID-stage bypass (only when MEM_FWD_EN is defined)
//
// Build option: define MEM_FWD_EN to add the fwd_* bypass outputs.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic [INST_W-1:0] ex_inst,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic [XLEN-1:0]   ex_vd,
    input  logic              ex_w_enable,
    input  logic [ADDR_W-1:0] ex_mem_addr,
    input  logic [XLEN-1:0]   ex_store_data,
    output logic [INST_W-1:0] mem_inst,
    output logic [REG_W-1:0]  mem_rd,
    output logic [XLEN-1:0]   mem_vd,
    output logic              mem_w_enable,
    output logic              mem_stall_req,
`ifdef MEM_FWD_EN
    output logic              fwd_w_enable,
    output logic [REG_W-1:0]  fwd_rd,
    output logic [XLEN-1:0]   fwd_vd,
`endif
    output logic              mc_req,
    output logic              mc_we,
    output logic [ADDR_W-1:0] mc_addr,
    output logic [BYTE_W-1:0] mc_wdata,
    input  logic [BYTE_W-1:0] mc_rdata,
    input  logic              mc_done
);

    state_e          state_q, state_d;
    logic [1:0]      k_q, k_d;
    logic [XLEN-1:0] asm_q, asm_d;

    logic            op_load, op_store;
    logic [2:0]      nbytes;
    logic            last_byte;
    logic [XLEN-1:0] ld_ext;

    assign op_load   = is_load(ex_inst);
    assign op_store  = is_store(ex_inst);
    assign nbytes    = byte_count(ex_inst);
    assign last_byte = ({1'b0, k_q} == (nbytes - 3'd1));

    assign mem_inst = ex_inst;
    assign mem_rd   = ex_rd;

    mem_ld_ext u_ld_ext (
        .data_i   (asm_q),
        .nbytes_i (nbytes),
        .signed_i (is_signed_load(ex_inst)),
        .ext_o    (ld_ext)
    );

    // NOTE: every output and next-state signal gets a default before the
    // case statement so no path leaves one unassigned and infers a latch.
    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        asm_d         = asm_q;
        mem_vd        = ex_vd;
        mem_w_enable  = ex_w_enable;
        mem_stall_req = 1'b0;
        mc_req        = 1'b0;
        mc_we         = 1'b0;
        mc_addr       = '0;
        mc_wdata      = '0;

        case (state_q)
            ST_IDLE: begin
                if (op_load || op_store) begin
                    mem_stall_req = 1'b1;
                    mem_w_enable  = 1'b0;
                    state_d       = ST_ACCESS;
                    k_d           = 2'd0;
                    asm_d         = '0;
                end
            end

            ST_ACCESS: begin
                mem_stall_req = 1'b1;
                mem_w_enable  = 1'b0;
                mc_req        = 1'b1;
                mc_we         = op_store;
                // Address and write byte derive from the registered k, so
                // they only move on the edge that follows an mc_done.
                mc_addr       = ex_mem_addr + ADDR_W'(k_q);
                mc_wdata      = ex_store_data[{k_q, 3'b000} +: BYTE_W];
                if (mc_done) begin
                    if (op_load) begin
                        asm_d[{k_q, 3'b000} +: BYTE_W] = mc_rdata;
                    end
                    k_d = k_q + 2'd1;
                    if (last_byte) begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                if (op_load) begin
                    mem_vd       = ld_ext;
                    mem_w_enable = ex_w_enable;
                end else begin
                    mem_vd       = '0;
                    mem_w_enable = 1'b0;
                end
                state_d = ST_IDLE;
                k_d     = 2'd0;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values regardless of statement order. Holding on !rdy also
    // drops any mc_done seen during the freeze.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            k_q     <= 2'd0;
            asm_q   <= '0;
        end else if (rdy) begin
            state_q <= state_d;
            k_q     <= k_d;
            asm_q   <= asm_d;
        end
    end

`ifdef MEM_FWD_EN
    assign fwd_w_enable = mem_stall_req ? 1'b0 : mem_w_enable;
    assign fwd_rd       = mem_rd;
    assign fwd_vd       = mem_vd;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage -- directed self-checking bench for mem_stage.
//
// Each cycle: inputs are driven 1 ns after the rising edge, outputs are
// checked 1 ns later, then the bench waits for the next rising edge.
`timescale 1ns/1ps
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              rdy;
    logic [INST_W-1:0] ex_inst;
    logic [REG_W-1:0]  ex_rd;
    logic [XLEN-1:0]   ex_vd;
    logic              ex_w_enable;
    logic [31:0]       ex_mem_addr;
    logic [XLEN-1:0]   ex_store_data;
    logic [INST_W-1:0] mem_inst;
    logic [REG_W-1:0]  mem_rd;
    logic [XLEN-1:0]   mem_vd;
    logic              mem_w_enable;
    logic              mem_stall_req;
`ifdef MEM_FWD_EN
    logic              fwd_w_enable;
    logic [REG_W-1:0]  fwd_rd;
    logic [XLEN-1:0]   fwd_vd;
`endif
    logic              mc_req;
    logic              mc_we;
    logic [31:0]       mc_addr;
    logic [7:0]        mc_wdata;
    logic [7:0]        mc_rdata;
    logic              mc_done;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_stage #(.ADDR_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .rdy           (rdy),
        .ex_inst       (ex_inst),
        .ex_rd         (ex_rd),
        .ex_vd         (ex_vd),
        .ex_w_enable   (ex_w_enable),
        .ex_mem_addr   (ex_mem_addr),
        .ex_store_data (ex_store_data),
        .mem_inst      (mem_inst),
        .mem_rd        (mem_rd),
        .mem_vd        (mem_vd),
        .mem_w_enable  (mem_w_enable),
        .mem_stall_req (mem_stall_req),
`ifdef MEM_FWD_EN
        .fwd_w_enable  (fwd_w_enable),
        .fwd_rd        (fwd_rd),
        .fwd_vd        (fwd_vd),
`endif
        .mc_req        (mc_req),
        .mc_we         (mc_we),
        .mc_addr       (mc_addr),
        .mc_wdata      (mc_wdata),
        .mc_rdata      (mc_rdata),
        .mc_done       (mc_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Cycle 0 of a memory op: stall raised, no bus request yet.
    task automatic start_op(input inst_t inst, input logic [31:0] addr,
                            input logic [31:0] sdata, input string tag);
        ex_inst       = inst;
        ex_rd         = 5'd7;
        ex_vd         = 32'h0BAD_0BAD;
        ex_w_enable   = 1'b1;
        ex_mem_addr   = addr;
        ex_store_data = sdata;
        mc_done       = 1'b0;
        #1;
        check({tag, " idle stall"}, mem_stall_req, 1);
        check({tag, " idle wen"},   mem_w_enable, 0);
        check({tag, " idle req"},   mc_req, 0);
        next_cycle();
    endtask

    // One byte: an address cycle, then a cycle with mc_done high.
    task automatic serve(input logic [31:0] addr, input logic we, input logic [7:0] wd,
                         input logic [7:0] rbyte, input string tag);
        mc_done = 1'b0;
        #1;
        check({tag, " req"},   mc_req, 1);
        check({tag, " addr"},  mc_addr, addr);
        check({tag, " we"},    mc_we, we);
        check({tag, " stall"}, mem_stall_req, 1);
        check({tag, " wen"},   mem_w_enable, 0);
        if (we) check({tag, " wdata"}, mc_wdata, wd);
        next_cycle();
        mc_done  = 1'b1;
        mc_rdata = rbyte;
        #1;
        check({tag, " addr hold"}, mc_addr, addr);
        check({tag, " stall2"},    mem_stall_req, 1);
        next_cycle();
        mc_done  = 1'b0;
        mc_rdata = 8'h00;
    endtask

    task automatic finish_op(input logic [31:0] vd, input logic wen, input string tag);
        #1;
        check({tag, " done stall"}, mem_stall_req, 0);
        check({tag, " done vd"},    mem_vd, vd);
        check({tag, " done wen"},   mem_w_enable, wen);
        check({tag, " done req"},   mc_req, 0);
        next_cycle();
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1;
        ex_inst = INST_NOP; ex_rd = '0; ex_vd = '0; ex_w_enable = 1'b0;
        ex_mem_addr = '0; ex_store_data = '0; mc_rdata = '0; mc_done = 1'b0;
        next_cycle();
        rst = 1'b0;
        #1;
        check("rst req",   mc_req, 0);
        check("rst we",    mc_we, 0);
        check("rst addr",  mc_addr, 0);
        check("rst wdata", mc_wdata, 0);
        check("rst stall", mem_stall_req, 0);

        // Non-memory pass-through; a stray mc_done must be ignored.
        ex_inst = INST_ADD; ex_vd = 32'h1234_5678; ex_rd = 5'd5; ex_w_enable = 1'b1;
        mc_done = 1'b1;
        #1;
        check("add vd",    mem_vd, 32'h1234_5678);
        check("add wen",   mem_w_enable, 1);
        check("add stall", mem_stall_req, 0);
        check("add req",   mc_req, 0);
        check("add rd",    mem_rd, 5'd5);
        check("add inst",  mem_inst, INST_ADD);
        next_cycle();
        mc_done = 1'b0;
        #1;
        check("add stray done req", mc_req, 0);
        check("add stray stall",    mem_stall_req, 0);

        // LW at 0x100 -> 0xDEADBEEF, stall cycles 0..8, DONE in cycle 9.
        start_op(INST_LW, 32'h100, 32'h0, "lw");
        serve(32'h100, 1'b0, 8'h00, 8'hEF, "lw b0");
        serve(32'h101, 1'b0, 8'h00, 8'hBE, "lw b1");
        serve(32'h102, 1'b0, 8'h00, 8'hAD, "lw b2");
        serve(32'h103, 1'b0, 8'h00, 8'hDE, "lw b3");
        finish_op(32'hDEAD_BEEF, 1'b1, "lw");

        // LB then LBU back to back, byte 0x80.
        start_op(INST_LB, 32'h200, 32'h0, "lb");
        serve(32'h200, 1'b0, 8'h00, 8'h80, "lb b0");
        finish_op(32'hFFFF_FF80, 1'b1, "lb");
        start_op(INST_LBU, 32'h200, 32'h0, "lbu");
        serve(32'h200, 1'b0, 8'h00, 8'h80, "lbu b0");
        finish_op(32'h0000_0080, 1'b1, "lbu");

        // SH across the top of the address space.
        start_op(INST_SH, 32'hFFFF_FFFF, 32'h0000_A55A, "sh");
        serve(32'hFFFF_FFFF, 1'b1, 8'h5A, 8'h00, "sh b0");
        serve(32'h0000_0000, 1'b1, 8'hA5, 8'h00, "sh b1");
        finish_op(32'h0, 1'b0, "sh");

        // Reset during byte 2 of LW, then the same LW re-run cleanly.
        start_op(INST_LW, 32'h300, 32'h0, "lwr");
        serve(32'h300, 1'b0, 8'h00, 8'hAA, "lwr b0");
        serve(32'h301, 1'b0, 8'h00, 8'hBB, "lwr b1");
        #1;
        check("lwr b2 addr", mc_addr, 32'h302);
        check("lwr b2 req",  mc_req, 1);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        #1;
        check("lwr post-rst req",   mc_req, 0);
        check("lwr post-rst addr",  mc_addr, 0);
        check("lwr post-rst stall", mem_stall_req, 1);
        next_cycle();
        serve(32'h300, 1'b0, 8'h00, 8'h11, "lw2 b0");
        serve(32'h301, 1'b0, 8'h00, 8'h22, "lw2 b1");
        serve(32'h302, 1'b0, 8'h00, 8'h33, "lw2 b2");
        serve(32'h303, 1'b0, 8'h00, 8'h44, "lw2 b3");
        finish_op(32'h4433_2211, 1'b1, "lw2");

        // LH with a 3-cycle rdy freeze during byte 1; done pulses ignored.
        start_op(INST_LH, 32'h400, 32'h0, "lh");
        serve(32'h400, 1'b0, 8'h00, 8'h34, "lh b0");
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mc_done  = 1'b1;
            mc_rdata = 8'h99;
            #1;
            check("lh frz addr",  mc_addr, 32'h401);
            check("lh frz req",   mc_req, 1);
            check("lh frz stall", mem_stall_req, 1);
            next_cycle();
        end
        rdy = 1'b1;
        mc_done = 1'b0;
        serve(32'h401, 1'b0, 8'h00, 8'hF2, "lh b1");
        finish_op(32'hFFFF_F234, 1'b1, "lh");

        ex_inst = INST_NOP; ex_w_enable = 1'b0;
        #1;
        check("tail stall", mem_stall_req, 0);
        check("tail req",   mc_req, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
